// File: rtl/io_dec_pkg.sv
// Shared types and constants for the I/O device decoder.
package io_dec_pkg;

  // Decoder FSM states.
  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    HOLD
  } dec_state_e;

  // Address bits [31:20] of every access routed to this decoder.
  localparam logic [11:0] IO_BASE = 12'hFFD;

  // Width of the slot field caps the number of device slots.
  localparam int unsigned MAX_SLOTS = 16;

  // Read data returned with any error ack unless overridden.
  localparam logic [31:0] ERR_DATA_DFLT = 32'hDEADBEEF;

  // Timeout counter width; the counter saturates at its all-ones value.
  localparam int unsigned CTR_W = 10;

endpackage

// File: rtl/io_timeout_ctr.sv
// Saturating cycle counter that flags when a programmed limit is reached.
module io_timeout_ctr
  import io_dec_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CTR_W-1:0] limit_i,
  output logic             expired_o
);

  logic [CTR_W-1:0] r_cnt;

  // Count enabled cycles; clear wins over enable; hold at all-ones.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (clr_i) begin
      r_cnt <= '0;
    end else if (en_i && (r_cnt != {CTR_W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign expired_o = (r_cnt == limit_i);

endmodule

// File: rtl/io_device_decoder.sv
// Fans one bridge request out to a single device slot and returns its ack,
// converting unmapped slots and silent devices into an error ack.
module io_device_decoder
  import io_dec_pkg::*;
#(
  parameter int unsigned NDEV       = 8,
  parameter int unsigned SLOT_LSB   = 16,
  parameter int unsigned TMO_CYCLES = 255,
  parameter logic [31:0] ERR_DATA   = ERR_DATA_DFLT
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               s_cyc_i,
  input  logic               s_stb_i,
  input  logic               s_we_i,
  input  logic [3:0]         s_sel_i,
  input  logic [31:0]        s_adr_i,
  input  logic [31:0]        s_dat_i,
  output logic               s_ack_o,
  output logic               s_err_o,
  output logic [31:0]        s_dat_o,
  output logic [NDEV-1:0]    d_cyc_o,
  output logic [NDEV-1:0]    d_stb_o,
  output logic               d_we_o,
  output logic [3:0]         d_sel_o,
  output logic [31:0]        d_adr_o,
  output logic [31:0]        d_dat_o,
  input  logic [NDEV-1:0]    d_ack_i,
  input  logic [32*NDEV-1:0] d_dat_i
);

  localparam logic [CTR_W-1:0] TmoLimit = CTR_W'(TMO_CYCLES - 1);

  dec_state_e       r_state, w_state_nxt;
  logic [3:0]       r_slot, w_slot_nxt;
  logic [NDEV-1:0]  r_dsel, w_dsel_nxt;
  logic             r_ack, w_ack_nxt;
  logic             r_err, w_err_nxt;
  logic [31:0]      r_sdat, w_sdat_nxt;
  logic             r_we, w_we_nxt;
  logic [3:0]       r_sel, w_sel_nxt;
  logic [31:0]      r_adr, w_adr_nxt;
  logic [31:0]      r_wdat, w_wdat_nxt;

  logic [3:0]       w_slot;
  logic             w_mapped;
  logic [NDEV-1:0]  w_onehot;
  logic             w_dev_ack;
  logic [31:0]      w_rdat;
  logic             w_ctr_clr;
  logic             w_expired;

  assign w_slot   = s_adr_i[SLOT_LSB+3:SLOT_LSB];
  assign w_mapped = ({1'b0, w_slot} < 5'(NDEV));

  // Decode the incoming slot to a one-hot device select.
  always_comb begin
    w_onehot = '0;
    for (int k = 0; k < NDEV; k++) begin
      w_onehot[k] = (w_slot == 4'(k));
    end
  end

  // Masking with the live select ignores acks from any other slot.
  assign w_dev_ack = |(d_ack_i & r_dsel);

  // Read-data mux keyed by the latched slot.
  always_comb begin
    w_rdat = '0;
    for (int k = 0; k < NDEV; k++) begin
      if (r_slot == 4'(k)) begin
        w_rdat = d_dat_i[32*k +: 32];
      end
    end
  end

  io_timeout_ctr u_tmo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (w_ctr_clr),
    .en_i      (r_state == ACTIVE),
    .limit_i   (TmoLimit),
    .expired_o (w_expired)
  );

  // Next-state and registered-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot;
    w_dsel_nxt  = r_dsel;
    w_ack_nxt   = r_ack;
    w_err_nxt   = r_err;
    w_sdat_nxt  = r_sdat;
    w_we_nxt    = r_we;
    w_sel_nxt   = r_sel;
    w_adr_nxt   = r_adr;
    w_wdat_nxt  = r_wdat;
    w_ctr_clr   = 1'b0;

    unique case (r_state)
      IDLE: begin
        if (s_cyc_i && s_stb_i && !r_ack) begin
          w_we_nxt   = s_we_i;
          w_sel_nxt  = s_sel_i;
          w_adr_nxt  = s_adr_i;
          w_wdat_nxt = s_dat_i;
          w_slot_nxt = w_slot;
          if (w_mapped) begin
            w_dsel_nxt  = w_onehot;
            w_ctr_clr   = 1'b1;
            w_state_nxt = ACTIVE;
          end else begin
            w_ack_nxt   = 1'b1;
            w_err_nxt   = 1'b1;
            w_sdat_nxt  = ERR_DATA;
            w_state_nxt = HOLD;
          end
        end
      end
      ACTIVE: begin
        if (!s_cyc_i) begin
          w_dsel_nxt  = '0;
          w_state_nxt = IDLE;
        end else if (w_dev_ack) begin
          w_ack_nxt   = 1'b1;
          w_err_nxt   = 1'b0;
          w_sdat_nxt  = w_rdat;
          w_dsel_nxt  = '0;
          w_state_nxt = HOLD;
        end else if (w_expired) begin
          w_ack_nxt   = 1'b1;
          w_err_nxt   = 1'b1;
          w_sdat_nxt  = ERR_DATA;
          w_dsel_nxt  = '0;
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        // s_dat_o deliberately keeps its last value after the ack clears.
        if (!s_stb_i) begin
          w_ack_nxt   = 1'b0;
          w_err_nxt   = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_dsel_nxt  = '0;
        w_ack_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and output registers; reset drops device strobes immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_slot  <= '0;
      r_dsel  <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      r_sdat  <= '0;
      r_we    <= 1'b0;
      r_sel   <= '0;
      r_adr   <= '0;
      r_wdat  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_slot  <= w_slot_nxt;
      r_dsel  <= w_dsel_nxt;
      r_ack   <= w_ack_nxt;
      r_err   <= w_err_nxt;
      r_sdat  <= w_sdat_nxt;
      r_we    <= w_we_nxt;
      r_sel   <= w_sel_nxt;
      r_adr   <= w_adr_nxt;
      r_wdat  <= w_wdat_nxt;
    end
  end

  assign s_ack_o = r_ack;
  assign s_err_o = r_err;
  assign s_dat_o = r_sdat;
  assign d_cyc_o = r_dsel;
  assign d_stb_o = r_dsel;
  assign d_we_o  = r_we;
  assign d_sel_o = r_sel;
  assign d_adr_o = r_adr;
  assign d_dat_o = r_wdat;

endmodule

// File: tb/tb_io_device_decoder.sv
// Scoreboard bench for io_device_decoder: expected acks are queued when a
// request is driven and compared when the decoder returns its ack.
module tb_io_device_decoder;
  import io_dec_pkg::*;

  localparam int unsigned NDEV     = 8;
  localparam int unsigned SLOT_LSB = 16;
  localparam int unsigned TMO      = 16;
  localparam logic [31:0] ERRD     = 32'hDEADBEEF;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               s_cyc_i, s_stb_i, s_we_i;
  logic [3:0]         s_sel_i;
  logic [31:0]        s_adr_i, s_dat_i;
  logic               s_ack_o, s_err_o;
  logic [31:0]        s_dat_o;
  logic [NDEV-1:0]    d_cyc_o, d_stb_o;
  logic               d_we_o;
  logic [3:0]         d_sel_o;
  logic [31:0]        d_adr_o, d_dat_o;
  logic [NDEV-1:0]    d_ack_i;
  logic [32*NDEV-1:0] d_dat_i;

  typedef struct packed {
    logic        err;
    logic [31:0] dat;
    int          lat;
    logic [7:0]  mask;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  io_device_decoder #(
    .NDEV       (NDEV),
    .SLOT_LSB   (SLOT_LSB),
    .TMO_CYCLES (TMO),
    .ERR_DATA   (ERRD)
  ) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .s_cyc_i (s_cyc_i),
    .s_stb_i (s_stb_i),
    .s_we_i  (s_we_i),
    .s_sel_i (s_sel_i),
    .s_adr_i (s_adr_i),
    .s_dat_i (s_dat_i),
    .s_ack_o (s_ack_o),
    .s_err_o (s_err_o),
    .s_dat_o (s_dat_o),
    .d_cyc_o (d_cyc_o),
    .d_stb_o (d_stb_o),
    .d_we_o  (d_we_o),
    .d_sel_o (d_sel_o),
    .d_adr_o (d_adr_o),
    .d_dat_o (d_dat_o),
    .d_ack_i (d_ack_i),
    .d_dat_i (d_dat_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One complete transfer. ack_dly: device acks on the ack_dly-th cycle it
  // sees its strobe (1 = same cycle); ack_dly <= 0 means the device is silent.
  task automatic bus_xfer(input string tag, input logic [3:0] slot, input logic [15:0] off,
                          input logic we, input logic [3:0] sel, input logic [31:0] wdat,
                          input int ack_dly, input logic [31:0] rdat,
                          input logic [NDEV-1:0] stray);
    exp_t            e, g;
    logic [31:0]     adr;
    logic [NDEV-1:0] stb_seen;
    int              c_stb, c_ack, cnt;
    logic            mapped;

    adr    = {IO_BASE, slot, off};
    mapped = (int'(slot) < NDEV);
    if (!mapped) begin
      e = '{err: 1'b1, dat: ERRD, lat: 1, mask: 8'h00};
    end else if (ack_dly <= 0) begin
      e = '{err: 1'b1, dat: ERRD, lat: TMO, mask: 8'(1 << slot)};
    end else begin
      e = '{err: 1'b0, dat: rdat, lat: ack_dly, mask: 8'(1 << slot)};
    end
    sb_q.push_back(e);

    s_adr_i  = adr;
    s_we_i   = we;
    s_sel_i  = sel;
    s_dat_i  = wdat;
    s_cyc_i  = 1'b1;
    s_stb_i  = 1'b1;
    d_ack_i  = stray;
    stb_seen = '0;
    c_stb    = -1;
    c_ack    = -1;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk_i);
      if (s_ack_o) begin
        c_ack = cyc;
        break;
      end
      stb_seen |= d_stb_o;
      if ((d_stb_o != '0) && (c_stb < 0)) begin
        c_stb = cyc;
        check_val({tag, "_adr"}, d_adr_o, adr);
        check_val({tag, "_sel"}, 32'(d_sel_o), 32'(sel));
        check_val({tag, "_we"}, 32'(d_we_o), 32'(we));
        check_val({tag, "_wdat"}, d_dat_o, wdat);
      end
      d_ack_i = stray;
      if ((c_stb >= 0) && (ack_dly > 0)) begin
        cnt = cyc - c_stb + 1;
        if (cnt == ack_dly) begin
          d_ack_i[slot[2:0]] = 1'b1;
          d_dat_i[32*slot[2:0] +: 32] = rdat;
        end
      end
    end

    if (c_ack < 0) begin
      check_val({tag, "_ack_timeout"}, 32'd0, 32'd1);
      if (sb_q.size() > 0) void'(sb_q.pop_front());
    end else if (sb_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      g = sb_q.pop_front();
      check_val({tag, "_err"}, 32'(s_err_o), 32'(g.err));
      check_val({tag, "_dat"}, s_dat_o, g.dat);
      check_val({tag, "_lat"}, mapped ? 32'(c_ack - c_stb) : 32'(c_ack), 32'(g.lat));
      check_val({tag, "_stbmask"}, 32'(stb_seen), 32'(g.mask));
      check_val({tag, "_cyc_drop"}, 32'(d_cyc_o), 32'd0);
    end

    // Bridge keeps stb high one more cycle: ack must hold.
    d_ack_i = '0;
    @(negedge clk_i);
    check_val({tag, "_hold_ack"}, 32'(s_ack_o), 32'd1);
    check_val({tag, "_hold_dat"}, s_dat_o, e.dat);
    s_cyc_i = 1'b0;
    s_stb_i = 1'b0;
    @(negedge clk_i);
    check_val({tag, "_ack_clr"}, 32'({s_ack_o, s_err_o}), 32'd0);
    check_val({tag, "_dat_keep"}, s_dat_o, e.dat);
    @(negedge clk_i);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_ack"}, 32'({s_ack_o, s_err_o}), 32'd0);
    check_val({tag, "_sdat"}, s_dat_o, 32'd0);
    check_val({tag, "_cycstb"}, 32'({d_cyc_o, d_stb_o}), 32'd0);
    check_val({tag, "_dbus"}, d_adr_o | d_dat_o | 32'({d_we_o, d_sel_o}), 32'd0);
  endtask

  initial begin
    logic            acc;
    logic [NDEV-1:0] seen;

    rst_i   = 1'b1;
    s_cyc_i = 1'b0;
    s_stb_i = 1'b0;
    s_we_i  = 1'b0;
    s_sel_i = '0;
    s_adr_i = '0;
    s_dat_i = '0;
    d_ack_i = '0;
    for (int k = 0; k < NDEV; k++) d_dat_i[32*k +: 32] = {16'hC0DE, 8'(k), 8'(k)};
    #2;
    check_reset_outputs("reset");
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);

    bus_xfer("rd_s2", 4'd2, 16'h0010, 1'b0, 4'hF, 32'h0, 3, 32'h12345678, '0);
    bus_xfer("wr_s0", 4'd0, 16'h0004, 1'b1, 4'b0011, 32'h0000A5A5, 2, 32'h0BADF00D, '0);
    bus_xfer("unm_s12", 4'd12, 16'h0000, 1'b0, 4'hF, 32'h0, 1, 32'h0, 8'h10);
    bus_xfer("tmo_s5", 4'd5, 16'h0100, 1'b0, 4'hF, 32'h0, 0, 32'h0, 8'h40);
    bus_xfer("rd_s7", 4'd7, 16'hFFFC, 1'b0, 4'hF, 32'h0, 1, 32'h7777AAAA, '0);
    bus_xfer("unm_s8", 4'd8, 16'h0000, 1'b1, 4'h1, 32'h11, 1, 32'h0, '0);

    // Abort: cyc drops in the same cycle the device acks, then the ack lingers.
    s_adr_i = {IO_BASE, 4'd3, 16'h0020};
    s_we_i  = 1'b0;
    s_sel_i = 4'hF;
    s_cyc_i = 1'b1;
    s_stb_i = 1'b1;
    seen    = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      seen = d_stb_o;
      if (seen != '0) break;
    end
    check_val("abort_stb", 32'(seen), 32'h08);
    s_cyc_i = 1'b0;
    s_stb_i = 1'b0;
    d_ack_i = 8'h08;
    d_dat_i[32*3 +: 32] = 32'h33333333;
    acc = 1'b0;
    @(negedge clk_i);
    acc |= s_ack_o;
    check_val("abort_drop", 32'(d_cyc_o), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      acc |= s_ack_o;
    end
    d_ack_i = '0;
    check_val("abort_noack", 32'(acc), 32'd0);
    @(negedge clk_i);
    bus_xfer("post_abort", 4'd3, 16'h0000, 1'b0, 4'hF, 32'h0, 2, 32'h3C3C3C3C, '0);

    // Reset mid-ACTIVE with the selected and an unselected device acking.
    s_adr_i = {IO_BASE, 4'd1, 16'h0000};
    s_cyc_i = 1'b1;
    s_stb_i = 1'b1;
    seen    = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_i);
      seen = d_stb_o;
      if (seen != '0) break;
    end
    check_val("rst_pre_stb", 32'(seen), 32'h02);
    d_ack_i = 8'h12;
    #1 rst_i = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    @(negedge clk_i);
    check_reset_outputs("rst_held");
    s_cyc_i = 1'b0;
    s_stb_i = 1'b0;
    d_ack_i = '0;
    rst_i   = 1'b0;
    @(negedge clk_i);
    bus_xfer("post_rst_s1", 4'd1, 16'h0008, 1'b0, 4'hF, 32'h0, 1, 32'hFACE0001, '0);

    check_val("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

endmodule
